// File: rtl/router_lookup_arbiter.sv
// router_lookup_arbiter: shares one router lookup pipeline between NUM_REQ
// requesters. It grants round-robin and tags each lookup in an in-order ID
// FIFO, so every router response is steered back to the requester that issued
// it. Lookups are withheld until the router table is loaded and are bounded by
// an in-flight credit limit. A sticky fault records the first error cause.
module router_lookup_arbiter #(
    parameter int NUM_REQ      = 4,
    parameter int MAX_INFLIGHT = 8,
    parameter int RESP_W       = 147
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [NUM_REQ-1:0]              req_valid,
    input  logic [NUM_REQ*32-1:0]           req_dst_ip,
    output logic [NUM_REQ-1:0]              req_ready,
    output logic                            lk_valid,
    output logic [31:0]                     lk_dst_ip,
    input  logic                            rt_resp_valid,
    input  logic [RESP_W-1:0]               rt_resp_bus,
    input  logic                            rt_init_done,
    input  logic                            rt_init_error,
    output logic [NUM_REQ-1:0]              rsp_valid,
    output logic [$clog2(NUM_REQ)-1:0]      rsp_id,
    output logic [RESP_W-1:0]               rsp_bus,
    output logic [$clog2(MAX_INFLIGHT):0]   inflight,
    output logic                            fault,
    output logic [1:0]                      fault_code
);

    localparam int ID_W  = $clog2(NUM_REQ);
    localparam int PTR_W = $clog2(MAX_INFLIGHT);
    localparam int CNT_W = PTR_W + 1;

    localparam logic [1:0] CODE_INIT_ERR = 2'd1;
    localparam logic [1:0] CODE_ORPHAN   = 2'd2;
    localparam logic [1:0] CODE_OVERFLOW = 2'd3;

    typedef enum logic [1:0] {ST_INIT, ST_RUN, ST_FAULT} state_t;

    state_t             state;
    logic [ID_W-1:0]    last_grant;
    logic [ID_W-1:0]    id_mem [MAX_INFLIGHT];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;

    logic               fifo_empty;
    logic               fifo_full;
    logic               can_issue;
    logic               grant_any;
    logic [ID_W-1:0]    grant_idx;
    logic [ID_W:0]      cand;
    logic               push;
    logic               pop;
    logic               orphan;
    logic               overflow;
    logic               init_fail;
    logic [ID_W-1:0]    head_id;
    logic [NUM_REQ-1:0] head_onehot;

    assign fifo_empty  = (inflight == '0);
    assign fifo_full   = (inflight == CNT_W'(MAX_INFLIGHT));
    // A response popping this cycle frees a credit for a same-cycle grant.
    assign can_issue   = (state == ST_RUN) && (!fifo_full || rt_resp_valid);
    assign push        = grant_any;
    assign pop         = rt_resp_valid && !fifo_empty;
    assign orphan      = rt_resp_valid && fifo_empty;
    // Unreachable while can_issue gates grants; kept as a safety net.
    assign overflow    = push && fifo_full && !pop;
    assign init_fail   = (state == ST_INIT) && rt_init_error;
    assign head_id     = id_mem[rd_ptr];
    assign head_onehot = NUM_REQ'(1) << head_id;

    // Round-robin search starting one past the last granted requester.
    always_comb begin
        grant_any = 1'b0;
        grant_idx = '0;
        cand      = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = {1'b0, last_grant} + (ID_W+1)'(k);
            if (cand >= (ID_W+1)'(NUM_REQ)) begin
                cand = cand - (ID_W+1)'(NUM_REQ);
            end
            if (!grant_any && req_valid[cand[ID_W-1:0]]) begin
                grant_any = 1'b1;
                grant_idx = cand[ID_W-1:0];
            end
        end
        if (!can_issue) begin
            grant_any = 1'b0;
            grant_idx = '0;
        end
    end

    // One-hot grant back to the requesters.
    always_comb begin
        req_ready = '0;
        if (grant_any) begin
            req_ready[grant_idx] = 1'b1;
        end
    end

    // Control FSM and sticky fault; only the first cause is recorded.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_INIT;
            fault      <= 1'b0;
            fault_code <= 2'd0;
        end else begin
            case (state)
                ST_INIT: begin
                    if (init_fail || orphan) begin
                        state <= ST_FAULT;
                    end else if (rt_init_done) begin
                        state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (orphan || overflow) begin
                        state <= ST_FAULT;
                    end
                end
                ST_FAULT: state <= ST_FAULT;
                default:  state <= ST_FAULT;
            endcase
            if (!fault) begin
                if (init_fail) begin
                    fault      <= 1'b1;
                    fault_code <= CODE_INIT_ERR;
                end else if (orphan) begin
                    fault      <= 1'b1;
                    fault_code <= CODE_ORPHAN;
                end else if (overflow) begin
                    fault      <= 1'b1;
                    fault_code <= CODE_OVERFLOW;
                end
            end
        end
    end

    // ID FIFO storage; stale entries are harmless once the pointers reset.
    always_ff @(posedge clk) begin
        if (push && !overflow) begin
            id_mem[wr_ptr] <= grant_idx;
        end
    end

    // ID FIFO pointers and in-flight count, which always equals occupancy.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            inflight <= '0;
        end else begin
            if (push && !overflow) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push && !overflow, pop})
                2'b10:   inflight <= inflight + CNT_W'(1);
                2'b01:   inflight <= inflight - CNT_W'(1);
                default: inflight <= inflight;
            endcase
        end
    end

    // Registered lookup issue and arbitration pointer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lk_valid   <= 1'b0;
            lk_dst_ip  <= '0;
            last_grant <= ID_W'(NUM_REQ - 1);
        end else begin
            lk_valid <= grant_any;
            if (grant_any) begin
                lk_dst_ip  <= req_dst_ip[32*int'(grant_idx) +: 32];
                last_grant <= grant_idx;
            end
        end
    end

    // Registered response steering to the owner at the FIFO head.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_valid <= '0;
            rsp_id    <= '0;
            rsp_bus   <= '0;
        end else begin
            rsp_valid <= pop ? head_onehot : '0;
            if (pop) begin
                rsp_id  <= head_id;
                rsp_bus <= rt_resp_bus;
            end
        end
    end

endmodule

// File: tb/tb_router_lookup_arbiter.sv
// Bench for router_lookup_arbiter: directed stimulus with a scoreboard of
// expected responses and a separate monitor that checks each response.
`timescale 1ns/1ps
module tb_router_lookup_arbiter;

    localparam int NUM_REQ      = 4;
    localparam int MAX_INFLIGHT = 8;
    localparam int RESP_W       = 147;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic [3:0]           req_valid;
    logic [127:0]         req_dst_ip;
    logic [3:0]           req_ready;
    logic                 lk_valid;
    logic [31:0]          lk_dst_ip;
    logic                 rt_resp_valid;
    logic [RESP_W-1:0]    rt_resp_bus;
    logic                 rt_init_done;
    logic                 rt_init_error;
    logic [3:0]           rsp_valid;
    logic [1:0]           rsp_id;
    logic [RESP_W-1:0]    rsp_bus;
    logic [3:0]           inflight;
    logic                 fault;
    logic [1:0]           fault_code;

    logic                 auto_mode;
    logic                 man_valid;
    logic [RESP_W-1:0]    man_bus;

    logic [31:0] ip_tab [4] = '{32'h0a32b7fa, 32'h0a32b708, 32'h0a32b77d, 32'h0a32b7dd};

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    typedef struct {
        logic [1:0]        id;
        logic [RESP_W-1:0] bus;
        int                due;
    } exp_t;
    exp_t sb[$];

    router_lookup_arbiter #(
        .NUM_REQ(NUM_REQ), .MAX_INFLIGHT(MAX_INFLIGHT), .RESP_W(RESP_W)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_dst_ip(req_dst_ip), .req_ready(req_ready),
        .lk_valid(lk_valid), .lk_dst_ip(lk_dst_ip),
        .rt_resp_valid(rt_resp_valid), .rt_resp_bus(rt_resp_bus),
        .rt_init_done(rt_init_done), .rt_init_error(rt_init_error),
        .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_bus(rsp_bus),
        .inflight(inflight), .fault(fault), .fault_code(fault_code)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Deterministic router table entry derived from the looked-up IP.
    function automatic logic [RESP_W-1:0] resp_of(input logic [31:0] ip);
        resp_of = {1'b1, ip[15:0], ip[31:16], ip ^ 32'h5a5a0001, ~ip[15:0],
                   ip[15:0] ^ 16'h1234, ip[23:0], ~ip[23:0], ip[0], ip[1]};
    endfunction

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_rsp(input int id, input logic [RESP_W-1:0] bus, input int lat);
        exp_t e;
        e.id  = 2'(id);
        e.bus = bus;
        e.due = cyc + lat;
        sb.push_back(e);
    endtask

    // Three-stage router model: answers lk_valid three cycles later.
    logic [2:0]       pv;
    logic [2:0][31:0] pip;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            pv  <= '0;
            pip <= '0;
        end else begin
            pv  <= {pv[1:0], lk_valid};
            pip <= {pip[1:0], lk_dst_ip};
        end
    end
    assign rt_resp_valid = auto_mode ? pv[2] : man_valid;
    assign rt_resp_bus   = auto_mode ? resp_of(pip[2]) : man_bus;

    // Response monitor: every rsp_valid must match the scoreboard head.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (!rst && rsp_valid != '0) begin
            if (sb.size() == 0) begin
                chk("rsp_unexpected", rsp_valid, 0);
            end else begin
                e = sb.pop_front();
                chk("rsp_valid", rsp_valid, 4'b0001 << e.id);
                chk("rsp_id", rsp_id, e.id);
                chk("rsp_bus", rsp_bus, e.bus);
                chk("rsp_cycle", cyc, e.due);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        req_valid     = '0;
        req_dst_ip    = {ip_tab[3], ip_tab[2], ip_tab[1], ip_tab[0]};
        rt_init_done  = 1'b0;
        rt_init_error = 1'b0;
        auto_mode     = 1'b1;
        man_valid     = 1'b0;
        man_bus       = '0;
        rst           = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);

        // Reset values
        chk("rst_lk_valid", lk_valid, 0);
        chk("rst_lk_dst_ip", lk_dst_ip, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_id", rsp_id, 0);
        chk("rst_rsp_bus", rsp_bus, 0);
        chk("rst_inflight", inflight, 0);
        chk("rst_fault", fault, 0);
        chk("rst_fault_code", fault_code, 0);
        chk("rst_req_ready", req_ready, 0);

        // Init hold, then round-robin through a 3-cycle router
        step();
        rst = 1'b0;
        req_valid = 4'hf;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("init_hold_ready", req_ready, 0);
            chk("init_hold_lk_valid", lk_valid, 0);
            step();
        end
        rt_init_done = 1'b1;
        @(negedge clk);
        chk("init_done_same_cycle_ready", req_ready, 0);
        for (int n = 0; n < 8; n++) begin
            step();
            @(negedge clk);
            chk("rr_grant", req_ready, 4'b0001 << (n % 4));
            expect_rsp(n % 4, resp_of(ip_tab[n % 4]), 5);
            if (n > 0) begin
                chk("rr_lk_valid", lk_valid, 1);
                chk("rr_lk_dst_ip", lk_dst_ip, ip_tab[(n - 1) % 4]);
            end
        end
        step();
        req_valid = '0;
        @(negedge clk);
        chk("rr_idle_ready", req_ready, 0);
        chk("rr_last_lk_valid", lk_valid, 1);
        chk("rr_last_lk_dst_ip", lk_dst_ip, ip_tab[3]);
        repeat (8) step();
        @(negedge clk);
        chk("rr_drained", sb.size(), 0);
        chk("rr_inflight_zero", inflight, 0);

        // Credit stall with responses withheld
        step();
        auto_mode = 1'b0;
        req_valid = 4'hf;
        for (int n = 0; n < 8; n++) begin
            @(negedge clk);
            chk("stall_grant", req_ready, 4'b0001 << (n % 4));
            step();
        end
        @(negedge clk);
        chk("stall_ready", req_ready, 0);
        chk("stall_inflight", inflight, 8);
        step();
        @(negedge clk);
        chk("stall_ready_hold", req_ready, 0);
        step();
        man_valid = 1'b1;
        man_bus   = resp_of(32'hdeadbeef);
        @(negedge clk);
        chk("stall_regrant", req_ready, 4'b0001);
        expect_rsp(0, resp_of(32'hdeadbeef), 1);
        step();
        man_valid = 1'b0;
        @(negedge clk);
        chk("stall_inflight_kept", inflight, 8);
        chk("stall_ready_again", req_ready, 0);

        // Mid-operation reset with three lookups outstanding
        step();
        rst = 1'b1;
        sb.delete();
        req_valid = '0;
        step();
        step();
        rst = 1'b0;
        auto_mode = 1'b1;
        req_valid = 4'b1110;
        @(negedge clk);
        chk("mid_init_ready", req_ready, 0);
        for (int n = 1; n <= 3; n++) begin
            step();
            @(negedge clk);
            chk("mid_grant", req_ready, 4'b0001 << n);
            expect_rsp(n, resp_of(ip_tab[n]), 5);
        end
        step();
        req_valid = '0;
        @(negedge clk);
        chk("mid_inflight3", inflight, 3);
        chk("mid_lk_valid", lk_valid, 1);
        #1;
        rst = 1'b1;
        sb.delete();
        #1;
        chk("mid_rst_lk_valid", lk_valid, 0);
        chk("mid_rst_lk_dst_ip", lk_dst_ip, 0);
        chk("mid_rst_inflight", inflight, 0);
        chk("mid_rst_rsp_valid", rsp_valid, 0);
        chk("mid_rst_rsp_id", rsp_id, 0);
        chk("mid_rst_rsp_bus", rsp_bus, 0);
        chk("mid_rst_fault", fault, 0);
        chk("mid_rst_fault_code", fault_code, 0);
        chk("mid_rst_req_ready", req_ready, 0);
        step();
        step();
        rst = 1'b0;
        req_valid = 4'hf;
        @(negedge clk);
        chk("post_rst_init_ready", req_ready, 0);
        step();
        @(negedge clk);
        chk("post_rst_first_grant", req_ready, 4'b0001);
        expect_rsp(0, resp_of(ip_tab[0]), 5);
        step();
        req_valid = '0;
        repeat (7) step();
        @(negedge clk);
        chk("post_rst_drained", sb.size(), 0);
        chk("post_rst_no_fault", fault, 0);

        // Orphan response
        step();
        auto_mode = 1'b0;
        man_valid = 1'b1;
        man_bus   = resp_of(32'h01020304);
        step();
        man_valid = 1'b0;
        @(negedge clk);
        chk("orphan_rsp_valid", rsp_valid, 0);
        chk("orphan_fault", fault, 1);
        chk("orphan_code", fault_code, 2);
        chk("orphan_inflight", inflight, 0);
        req_valid = 4'hf;
        for (int i = 0; i < 3; i++) begin
            step();
            @(negedge clk);
            chk("orphan_ready_blocked", req_ready, 0);
            chk("orphan_lk_valid", lk_valid, 0);
        end

        // Init error together with init done; later orphan must not overwrite
        step();
        rst = 1'b1;
        rt_init_done  = 1'b1;
        rt_init_error = 1'b1;
        step();
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("initerr_ready", req_ready, 0);
            chk("initerr_lk_valid", lk_valid, 0);
            if (i > 0) begin
                chk("initerr_fault", fault, 1);
                chk("initerr_code", fault_code, 1);
            end
            step();
            man_valid = (i == 4);
        end
        man_valid = 1'b0;
        @(negedge clk);
        chk("initerr_code_sticky", fault_code, 1);
        chk("initerr_rsp_valid", rsp_valid, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
